// File: rtl/sum_seq_ctrl.sv
// rtl/sum_seq_ctrl.sv - control FSM sequencing the register-file/ALU datapath to compute sum(1..n); optional MAX_N_CHECK_EN
module sum_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int MAX_N = 22
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] n_value,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             error,
    input  logic             n_is_0,
    input  logic [WIDTH-1:0] run_sum,
    output logic [WIDTH-1:0] n_in,
    output logic             input_enable_mux,
    output logic             WE,
    output logic             RAE,
    output logic             RBE,
    output logic             output_enable_buf,
    output logic [1:0]       WA,
    output logic [1:0]       RAA,
    output logic [1:0]       RBA,
    output logic [2:0]       alu_op,
    output logic [1:0]       shift_op
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_LOAD,
        S_TEST,
        S_ADD,
        S_DEC,
        S_OUT
`ifdef MAX_N_CHECK_EN
        , S_REJECT
`endif
    } state_t;

    typedef struct packed {
        logic       ie_mux;
        logic       we;
        logic [1:0] wa;
        logic       rae;
        logic [1:0] raa;
        logic       rbe;
        logic [1:0] rba;
        logic [2:0] alu;
        logic       oe;
    } ctrl_t;

    state_t state;
    state_t state_next;
    ctrl_t  ctrl;

    // Control word for a state; registered from the next state so outputs are Moore and glitch-free.
    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_INIT: begin
                c.we  = 1'b1; c.wa  = 2'b00;
                c.rae = 1'b1; c.raa = 2'b00;
                c.rbe = 1'b1; c.rba = 2'b00;
                c.alu = 3'b101;
            end
            S_LOAD: begin
                c.ie_mux = 1'b1;
                c.we     = 1'b1; c.wa = 2'b01;
            end
            S_TEST: begin
                c.rae = 1'b1; c.raa = 2'b01;
                c.alu = 3'b000;
            end
            S_ADD: begin
                c.we  = 1'b1; c.wa  = 2'b00;
                c.rae = 1'b1; c.raa = 2'b00;
                c.rbe = 1'b1; c.rba = 2'b01;
                c.alu = 3'b100;
            end
            S_DEC: begin
                c.we  = 1'b1; c.wa  = 2'b01;
                c.rae = 1'b1; c.raa = 2'b01;
                c.alu = 3'b111;
            end
            S_OUT: begin
                c.rae = 1'b1; c.raa = 2'b00;
                c.alu = 3'b000;
                c.oe  = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
`ifdef MAX_N_CHECK_EN
                    if (n_value > WIDTH'(MAX_N))
                        state_next = S_REJECT;
                    else
                        state_next = S_INIT;
`else
                    state_next = S_INIT;
`endif
                end
            end
            S_INIT:  state_next = S_LOAD;
            S_LOAD:  state_next = S_TEST;
            S_TEST:  state_next = n_is_0 ? S_OUT : S_ADD;
            S_ADD:   state_next = S_DEC;
            // n_is_0 here reflects the decremented counter value
            S_DEC:   state_next = n_is_0 ? S_OUT : S_ADD;
            S_OUT:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

`ifdef MAX_N_CHECK_EN
    logic error_q;
    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            ctrl   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            n_in   <= '0;
`ifdef MAX_N_CHECK_EN
            error_q <= 1'b0;
`endif
        end else begin
            state <= state_next;
            ctrl  <= decode(state_next);
            busy  <= (state_next != S_IDLE);
`ifdef MAX_N_CHECK_EN
            done    <= (state_next == S_OUT) || (state_next == S_REJECT);
            error_q <= (state_next == S_REJECT);
`else
            done    <= (state_next == S_OUT);
`endif
            if (state == S_IDLE && state_next == S_INIT)
                n_in <= n_value;
            if (state == S_OUT)
                result <= run_sum;
        end
    end

    assign input_enable_mux  = ctrl.ie_mux;
    assign WE                = ctrl.we;
    assign WA                = ctrl.wa;
    assign RAE               = ctrl.rae;
    assign RAA               = ctrl.raa;
    assign RBE               = ctrl.rbe;
    assign RBA               = ctrl.rba;
    assign alu_op            = ctrl.alu;
    assign output_enable_buf = ctrl.oe;
    assign shift_op          = 2'b00;

endmodule

// File: tb/tb_sum_seq_ctrl.sv
// tb/tb_sum_seq_ctrl.sv - directed bench for sum_seq_ctrl with a behavioural register-file/ALU datapath
module tb_sum_seq_ctrl;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       start;
    logic [7:0] n_value;
    logic       busy, done, error;
    logic [7:0] result;
    logic       n_is_0;
    logic [7:0] run_sum;
    logic [7:0] n_in;
    logic       input_enable_mux, WE, RAE, RBE, output_enable_buf;
    logic [1:0] WA, RAA, RBA;
    logic [2:0] alu_op;
    logic [1:0] shift_op;

    int compared = 0;
    int mismatched = 0;

    always #5 clock = ~clock;

    sum_seq_ctrl #(.WIDTH(8), .MAX_N(22)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .n_value(n_value),
        .busy(busy), .done(done), .result(result), .error(error),
        .n_is_0(n_is_0), .run_sum(run_sum), .n_in(n_in),
        .input_enable_mux(input_enable_mux), .WE(WE), .RAE(RAE), .RBE(RBE),
        .output_enable_buf(output_enable_buf), .WA(WA), .RAA(RAA), .RBA(RBA),
        .alu_op(alu_op), .shift_op(shift_op)
    );

    // Datapath: 4x8 register file, two read ports, ALU, zero-detect, output buffer
    logic [7:0] rf [4] = '{8'h5a, 8'h33, 8'h11, 8'h77};
    logic [7:0] a_bus, b_bus, alu_res;

    always_comb begin
        a_bus = RAE ? rf[RAA] : 8'h00;
        b_bus = RBE ? rf[RBA] : 8'h00;
        case (alu_op)
            3'b100:  alu_res = a_bus + b_bus;
            3'b101:  alu_res = a_bus - b_bus;
            3'b111:  alu_res = a_bus - 8'd1;
            default: alu_res = a_bus;
        endcase
        n_is_0  = (alu_res == 8'h00);
        run_sum = output_enable_buf ? alu_res : 8'h00;
    end

    always_ff @(posedge clock) begin
        if (WE)
            rf[WA] <= input_enable_mux ? n_in : alu_res;
    end

    task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    int  cyc, done_at, done_cnt, adds;
    bit  saw_add, we_bad, we_seen, err_at_done;
    logic [7:0] n_in_seen;

    // Called at a negedge; runs until busy drops, optionally injecting a stray start at cycle inj.
    task automatic run_op(input logic [7:0] n, input bit hold, input int inj);
        start   = 1'b1;
        n_value = n;
        @(negedge clock);
        if (!hold) start = 1'b0;
        cyc = 0; done_at = 0; done_cnt = 0;
        saw_add = 0; we_bad = 0; we_seen = 0; err_at_done = 0;
        n_in_seen = n_in;
        while (busy && cyc < 600) begin
            cyc++;
            if (done) begin done_at = cyc; done_cnt++; err_at_done = error; end
            if (alu_op == 3'b100) saw_add = 1;
            if (WE) we_seen = 1;
            if (output_enable_buf && WE) we_bad = 1;
            if (RAE && RAA == 2'b01 && alu_op == 3'b000 && WE) we_bad = 1;
            if (inj != 0 && cyc == inj) begin start = 1'b1; n_value = 8'd9; end
            if (inj != 0 && cyc == inj + 1) start = 1'b0;
            @(negedge clock);
        end
        expect_eq("op_terminated", (cyc < 600), 1);
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        n_value = 8'd0;
        @(negedge clock);
        expect_eq("rst_busy", busy, 0);
        expect_eq("rst_done", done, 0);
        expect_eq("rst_error", error, 0);
        expect_eq("rst_result", result, 0);
        expect_eq("rst_n_in", n_in, 0);
        expect_eq("rst_ctrl", {input_enable_mux, WE, RAE, RBE, output_enable_buf, WA, RAA, RBA, alu_op, shift_op}, 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        run_op(8'd3, 0, 0);
        expect_eq("n3_busy_cycles", cyc, 10);
        expect_eq("n3_done_cycle", done_at, 10);
        expect_eq("n3_done_count", done_cnt, 1);
        expect_eq("n3_error", err_at_done, 0);
        expect_eq("n3_result", result, 6);
        expect_eq("n3_n_in", n_in_seen, 3);
        expect_eq("n3_we_test_out", we_bad, 0);
        expect_eq("n3_idle_done", done, 0);

        run_op(8'd0, 0, 0);
        expect_eq("n0_done_cycle", done_at, 4);
        expect_eq("n0_busy_cycles", cyc, 4);
        expect_eq("n0_result", result, 0);
        expect_eq("n0_no_add", saw_add, 0);

        run_op(8'd22, 1, 0);
        expect_eq("n22_result", result, 253);
        expect_eq("n22_busy_cycles", cyc, 48);
        expect_eq("gap_idle", busy, 0);
        n_value = 8'd23;
        run_op(8'd23, 0, 0);
        expect_eq("n23_busy_cycles", cyc, 50);
        expect_eq("n23_result_wrapped", result, 20);
        expect_eq("n23_n_in", n_in_seen, 23);

        run_op(8'd4, 0, 3);
        expect_eq("ign_result", result, 10);
        expect_eq("ign_n_in", n_in, 4);
        expect_eq("ign_busy_cycles", cyc, 12);
        @(negedge clock);
        expect_eq("ign_no_restart", busy, 0);

`ifdef MAX_N_CHECK_EN
        run_op(8'd23, 0, 0);
        expect_eq("rej_busy_cycles", cyc, 1);
        expect_eq("rej_done_cycle", done_at, 1);
        expect_eq("rej_error", err_at_done, 1);
        expect_eq("rej_result_kept", result, 10);
        expect_eq("rej_no_we", we_seen, 0);
`endif

        start   = 1'b1;
        n_value = 8'd5;
        @(negedge clock);
        start = 1'b0;
        adds = 0;
        cyc  = 0;
        while (cyc < 100) begin
            if (alu_op == 3'b100) begin
                adds++;
                if (adds == 3) break;
            end
            @(negedge clock);
            cyc++;
        end
        expect_eq("rst_third_add", adds, 3);
        reset_n = 1'b0;
        #1;
        expect_eq("abort_busy", busy, 0);
        expect_eq("abort_done", done, 0);
        expect_eq("abort_result", result, 0);
        expect_eq("abort_n_in", n_in, 0);
        expect_eq("abort_ctrl", {input_enable_mux, WE, RAE, RBE, output_enable_buf, WA, RAA, RBA, alu_op}, 0);
        done_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (done) done_cnt++;
        end
        reset_n = 1'b1;
        @(negedge clock);
        if (done) done_cnt++;
        expect_eq("abort_no_done", done_cnt, 0);

        run_op(8'd5, 0, 0);
        expect_eq("n5_result", result, 15);
        expect_eq("n5_busy_cycles", cyc, 14);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
